// File: rtl/stumps_bist_ctrl.sv
// rtl/stumps_bist_ctrl.sv - STUMPS self-test sequencer driving LFSR, scan chain and MISR
//
// Purpose:
//   Runs one self-test: seeds the LFSR and clears the MISR, then repeats
//   CHAIN_LEN shift cycles (TC=0) followed by one capture cycle (TC=1) for
//   NUM_PATTERNS patterns. It then flushes the last response into the MISR
//   and compares the signature with GOLDEN_SIG.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        run request, honoured in IDLE and DONE
//   abort        cancel run, honoured in every state, beats start
//   sig_in       current MISR signature
//   TC           0 = scan shift, 1 = functional capture
//   lfsr_load    seed the LFSR this cycle
//   misr_clr     clear the MISR this cycle
//   lfsr_en      advance the LFSR this cycle
//   misr_en      compact into the MISR this cycle
//   busy         run in progress (INIT through COMPARE)
//   done         run finished, pass is valid
//   pass         final signature matched GOLDEN_SIG
//   pattern_cnt  captures completed in this run
//
// Timing:
//   The state register moves on the edge that samples start. Every output is
//   a registered decode of that state and the counters, so outputs follow
//   the state by one cycle. With start sampled at edge 0, INIT outputs appear
//   after edge 1 and done rises at edge 2 + NUM_PATTERNS*(CHAIN_LEN+1) +
//   CHAIN_LEN + 1. No input reaches an output without passing a flop.

module stumps_bist_ctrl #(
    parameter int               CHAIN_LEN    = 3,
    parameter int               NUM_PATTERNS = 16,
    parameter int               SIG_W        = 3,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [SIG_W-1:0]                  sig_in,
    output logic                              TC,
    output logic                              lfsr_load,
    output logic                              misr_clr,
    output logic                              lfsr_en,
    output logic                              misr_en,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [$clog2(NUM_PATTERNS+1)-1:0] pattern_cnt
);

    localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam int SC_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    logic [SC_W-1:0]  shift_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             pass_r;

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            shift_cnt   <= '0;
            cnt         <= '0;
            pass_r      <= 1'b0;
            TC          <= 1'b0;
            lfsr_load   <= 1'b0;
            misr_clr    <= 1'b0;
            lfsr_en     <= 1'b0;
            misr_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            pattern_cnt <= '0;
        end else begin
            // Output stage: a decode of the state held during the previous cycle
            TC          <= (state == S_CAPTURE);
            lfsr_load   <= (state == S_INIT);
            misr_clr    <= (state == S_INIT);
            lfsr_en     <= (state == S_SHIFT);
            // The first chain fill has no captured response behind it, so
            // compaction starts only after the first capture.
            misr_en     <= ((state == S_SHIFT) && (cnt != '0)) || (state == S_FLUSH);
            busy        <= (state != S_IDLE) && (state != S_DONE);
            done        <= (state == S_DONE);
            pass        <= pass_r;
            pattern_cnt <= cnt;

            // Next-state logic. abort outranks everything. The capture count
            // is kept so the tester can see how far an aborted run got.
            if (abort && (state != S_IDLE)) begin
                state     <= S_IDLE;
                shift_cnt <= '0;
                pass_r    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state  <= S_INIT;
                            pass_r <= 1'b0;
                        end
                    end
                    S_INIT: begin
                        cnt       <= '0;
                        shift_cnt <= '0;
                        pass_r    <= 1'b0;
                        state     <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (shift_cnt == SC_LAST) begin
                            shift_cnt <= '0;
                            state     <= S_CAPTURE;
                        end else begin
                            shift_cnt <= shift_cnt + SC_W'(1);
                        end
                    end
                    S_CAPTURE: begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state <= S_FLUSH;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                    S_FLUSH: begin
                        // The flush reuses the shift counter to clock the last
                        // response out of the chain.
                        if (shift_cnt == SC_LAST) begin
                            shift_cnt <= '0;
                            state     <= S_COMPARE;
                        end else begin
                            shift_cnt <= shift_cnt + SC_W'(1);
                        end
                    end
                    S_COMPARE: begin
                        pass_r <= (sig_in == GOLDEN_SIG);
                        state  <= S_DONE;
                    end
                    S_DONE: begin
                        if (start) begin
                            state  <= S_INIT;
                            pass_r <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stumps_bist_ctrl.sv
// tb/tb_stumps_bist_ctrl.sv - self-checking bench for stumps_bist_ctrl

module tb_stumps_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] sig_in;
    logic       TC, lfsr_load, misr_clr, lfsr_en, misr_en, busy, done, pass;
    logic [4:0] pattern_cnt;

    logic       start2;
    logic       abort2;
    logic [2:0] sig_in2;
    logic       TC2, lfsr_load2, misr_clr2, lfsr_en2, misr_en2, busy2, done2, pass2;
    logic [0:0] pattern_cnt2;

    int errors;
    int checks;
    int edge_n;

    stumps_bist_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .sig_in      (sig_in),
        .TC          (TC),
        .lfsr_load   (lfsr_load),
        .misr_clr    (misr_clr),
        .lfsr_en     (lfsr_en),
        .misr_en     (misr_en),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .pattern_cnt (pattern_cnt)
    );

    stumps_bist_ctrl #(
        .CHAIN_LEN    (1),
        .NUM_PATTERNS (1),
        .SIG_W        (3),
        .GOLDEN_SIG   (3'b000)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .start       (start2),
        .abort       (abort2),
        .sig_in      (sig_in2),
        .TC          (TC2),
        .lfsr_load   (lfsr_load2),
        .misr_clr    (misr_clr2),
        .lfsr_en     (lfsr_en2),
        .misr_en     (misr_en2),
        .busy        (busy2),
        .done        (done2),
        .pass        (pass2),
        .pattern_cnt (pattern_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        edge_n = edge_n + 1;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; abort = 1'b0; sig_in = 3'b000;
        start2 = 1'b0; abort2 = 1'b0; sig_in2 = 3'b000;
        repeat (3) tick;
        checks++;
        if ({TC, lfsr_load, misr_clr, lfsr_en, misr_en, busy, done, pass, pattern_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 0",
                     {TC, lfsr_load, misr_clr, lfsr_en, misr_en, busy, done, pass, pattern_cnt});
        end
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if ({TC, lfsr_load, misr_clr, lfsr_en, misr_en, busy, done, pass, pattern_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_release: got %b expected 0",
                     {TC, lfsr_load, misr_clr, lfsr_en, misr_en, busy, done, pass, pattern_cnt});
        end
    endtask

    // One complete default run. Expected TC cycles and the done edge are
    // pushed when start is driven and popped as the DUT produces them.
    task automatic run_check(input logic [2:0] sig, input logic exp_pass, input bit restart_mid);
        int   s, rel, exp_e;
        logic prev_tc, prev_done;
        bit   seen_done;
        int   tc_q[$];
        int   done_q[$];
        sig_in = sig;
        start  = 1'b1;
        tick;
        s      = edge_n;
        start  = 1'b0;
        for (int p = 0; p < 16; p++) tc_q.push_back(s + (p + 1) * 4 + 1);
        done_q.push_back(s + 70);
        prev_tc   = 1'b0;
        prev_done = done;
        seen_done = 1'b0;
        for (int k = 0; k < 80 && !seen_done; k++) begin
            tick;
            rel = edge_n - s;
            if (restart_mid) start = (rel == 30);
            if (rel == 1) begin
                checks++;
                if ({busy, done, pass} !== 3'b100) begin
                    errors++;
                    $display("FAIL init_flags: got busy/done/pass=%b expected 100", {busy, done, pass});
                end
            end
            checks++;
            if ({lfsr_load, misr_clr} !== {2{rel == 1}}) begin
                errors++;
                $display("FAIL load_clr rel=%0d: got %b expected %b", rel, {lfsr_load, misr_clr}, {2{rel == 1}});
            end
            if (rel >= 2 && rel <= 4) begin
                checks++;
                if (misr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL first_fill_misr rel=%0d: got %b expected 0", rel, misr_en);
                end
            end
            if (rel == 6) begin
                checks++;
                if ({misr_en, lfsr_en} !== 2'b11) begin
                    errors++;
                    $display("FAIL second_shift_en: got %b expected 11", {misr_en, lfsr_en});
                end
            end
            if (TC) begin
                checks++;
                if (tc_q.size() == 0) begin
                    errors++;
                    $display("FAIL tc_extra: got TC at rel %0d expected none", rel);
                end else begin
                    exp_e = tc_q.pop_front();
                    if (edge_n != exp_e) begin
                        errors++;
                        $display("FAIL tc_cycle: got rel %0d expected rel %0d", rel, exp_e - s);
                    end
                end
                checks++;
                if (prev_tc) begin
                    errors++;
                    $display("FAIL tc_width: got 2+ cycle pulse at rel %0d expected 1", rel);
                end
            end
            if (done && !prev_done) begin
                seen_done = 1'b1;
                exp_e = done_q.pop_front();
                checks++;
                if (edge_n != exp_e) begin
                    errors++;
                    $display("FAIL done_edge: got rel %0d expected rel %0d", rel, exp_e - s);
                end
                checks++;
                if (pass !== exp_pass) begin
                    errors++;
                    $display("FAIL pass: got %b expected %b", pass, exp_pass);
                end
                checks++;
                if ({busy, pattern_cnt} !== {1'b0, 5'd16}) begin
                    errors++;
                    $display("FAIL done_state: got busy=%b cnt=%0d expected busy=0 cnt=16", busy, pattern_cnt);
                end
            end
            prev_tc   = TC;
            prev_done = done;
        end
        start = 1'b0;
        checks++;
        if (tc_q.size() != 0) begin
            errors++;
            $display("FAIL tc_missing: got %0d pulses expected 16", 16 - tc_q.size());
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done at rel 70");
        end
    endtask

    task automatic test_full_run;
        run_check(3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_check(3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_bad_signature;
        run_check(3'b101, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored;
        run_check(3'b000, 1'b1, 1'b1);
    endtask

    task automatic test_abort;
        bit tc_seen;
        sig_in = 3'b000;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        repeat (22) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        checks++;
        if ({busy, done, pass, lfsr_en, misr_en} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_flags: got %b expected 00000", {busy, done, pass, lfsr_en, misr_en});
        end
        checks++;
        if (pattern_cnt !== 5'd5) begin
            errors++;
            $display("FAIL abort_cnt: got %0d expected 5", pattern_cnt);
        end
        tc_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (TC || busy) tc_seen = 1'b1;
        end
        checks++;
        if (tc_seen) begin
            errors++;
            $display("FAIL abort_quiet: got activity after abort expected none");
        end
        run_check(3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_capture;
        bit found;
        start = 1'b1;
        tick;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick;
            if (TC) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL capture_wait: got no TC expected TC within 10 cycles");
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({TC, busy, lfsr_en, misr_en, pattern_cnt} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0", {TC, busy, lfsr_en, misr_en, pattern_cnt});
        end
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if ({TC, busy, lfsr_load, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000", {TC, busy, lfsr_load, done});
        end
    endtask

    task automatic test_small_config;
        int s, rel;
        sig_in2 = 3'b000;
        start2  = 1'b1;
        tick;
        s       = edge_n;
        start2  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            rel = edge_n - s;
            checks++;
            if ({lfsr_load2, lfsr_en2, TC2, misr_en2, busy2, done2} !==
                {rel == 1, rel == 2, rel == 3, rel == 4, (rel >= 1 && rel <= 5), rel >= 6}) begin
                errors++;
                $display("FAIL small_seq rel=%0d: got %b expected %b", rel,
                         {lfsr_load2, lfsr_en2, TC2, misr_en2, busy2, done2},
                         {rel == 1, rel == 2, rel == 3, rel == 4, (rel >= 1 && rel <= 5), rel >= 6});
            end
            if (rel == 6) begin
                checks++;
                if ({pass2, pattern_cnt2} !== 2'b11) begin
                    errors++;
                    $display("FAIL small_done: got pass/cnt=%b expected 11", {pass2, pattern_cnt2});
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        edge_n = 0;
        test_reset;
        test_full_run;
        test_back_to_back;
        test_bad_signature;
        test_start_ignored;
        test_abort;
        test_small_config;
        test_reset_mid_capture;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
